// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the digital clock mode/sequencing controller:
// mode encoding, mode width and a counter-width helper.
package clock_ctrl_pkg;

   localparam int unsigned MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_RUN     = 2'd0,
      MODE_SET_HR  = 2'd1,
      MODE_SET_MIN = 2'd2,
      MODE_ILLEGAL = 2'd3
   } mode_e;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_cond.sv
// Push-button conditioner: 2-flop synchronizer, level debounce and a
// single-cycle pulse on each accepted 0->1 transition.
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   btn    raw button level, asynchronous to clk
//   press  1-cycle pulse, 2 + DB_CYCLES + 1 cycles after a clean rising edge
module btn_cond
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 500_000
)(
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int unsigned DB_W = cnt_w(DB_CYCLES);

   logic            sync1;
   logic            sync2;
   logic            db_level;
   logic            db_prev;
   logic [DB_W-1:0] db_cnt;

   // Synchronizer, debounce counter and edge pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         db_level <= 1'b0;
         db_prev  <= 1'b0;
         db_cnt   <= '0;
         press    <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         // Count consecutive samples that disagree with the accepted level;
         // any agreeing sample restarts the count.
         if (sync2 == db_level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
            db_level <= sync2;
            db_cnt   <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
         db_prev <= db_level;
         press   <= db_level & ~db_prev;
      end
   end

endmodule

// File: rtl/clock_ctrl.sv
// Mode/sequencing controller for a 24 h digital clock: 1 Hz prescaler,
// button conditioning, RUN -> SET_HR -> SET_MIN mode FSM and count-enable
// decode for the seconds/minutes/hours BCD counters.
// Optional blink of the field being set when CLOCK_BLINK_EN is defined;
// otherwise blank is tied low and no blink logic exists.
// Ports:
//   clk       system clock
//   cr        asynchronous active-high reset
//   btn_mode  raw mode button (async)
//   btn_inc   raw increment button (async)
//   rco_sec   seconds counter at 59
//   rco_min   minutes counter at 59
//   en_sec    seconds count enable (combinational pulse)
//   en_min    minutes count enable (combinational pulse)
//   en_hr     hours count enable (combinational pulse)
//   clr_sec   seconds synchronous clear, registered 1-cycle pulse
//   mode      0=RUN 1=SET_HR 2=SET_MIN
//   blank     [1] blank hours, [0] blank minutes
module clock_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 50_000_000,
   parameter int unsigned DB_CYCLES = 500_000
`ifdef CLOCK_BLINK_EN
   ,
   parameter int unsigned BLINK_DIV = 12_500_000
`endif
)(
   input  logic              clk,
   input  logic              cr,
   input  logic              btn_mode,
   input  logic              btn_inc,
   input  logic              rco_sec,
   input  logic              rco_min,
   output logic              en_sec,
   output logic              en_min,
   output logic              en_hr,
   output logic              clr_sec,
   output logic [MODE_W-1:0] mode,
   output logic [1:0]        blank
);

   localparam int unsigned TICK_W = cnt_w(TICK_DIV);

   logic              p_mode;
   logic              p_inc;
   mode_e             state;
   mode_e             state_next;
   logic              mode_chg;
   logic [TICK_W-1:0] tick_cnt;
   logic              tick;

   btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_mode (
      .clk   (clk),
      .rst   (cr),
      .btn   (btn_mode),
      .press (p_mode)
   );

   btn_cond #(.DB_CYCLES(DB_CYCLES)) u_btn_inc (
      .clk   (clk),
      .rst   (cr),
      .btn   (btn_inc),
      .press (p_inc)
   );

   // Mode state register.
   always_ff @(posedge clk or posedge cr) begin
      if (cr) state <= MODE_RUN;
      else    state <= state_next;
   end

   // Mode next-state: advance on each mode press, recover from the unused code.
   always_comb begin
      state_next = state;
      case (state)
         MODE_RUN:     if (p_mode) state_next = MODE_SET_HR;
         MODE_SET_HR:  if (p_mode) state_next = MODE_SET_MIN;
         MODE_SET_MIN: if (p_mode) state_next = MODE_RUN;
         default:      state_next = MODE_RUN;
      endcase
   end

   assign mode_chg = (state_next != state);

   // Enable decode; a mode press in the same cycle swallows the increment.
   always_comb begin
      en_sec = 1'b0;
      en_min = 1'b0;
      en_hr  = 1'b0;
      case (state)
         MODE_RUN: begin
            en_sec = tick;
            en_min = tick & rco_sec;
            en_hr  = tick & rco_sec & rco_min;
         end
         MODE_SET_HR:  en_hr  = p_inc & ~p_mode;
         MODE_SET_MIN: en_min = p_inc & ~p_mode;
         default: ;
      endcase
   end

   // 1 Hz prescaler; restarts on every mode change so RUN begins a full second.
   always_ff @(posedge clk or posedge cr) begin
      if (cr) begin
         tick_cnt <= '0;
         tick     <= 1'b0;
      end else if (mode_chg) begin
         tick_cnt <= '0;
         tick     <= 1'b0;
      end else if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
         tick_cnt <= '0;
         tick     <= 1'b1;
      end else begin
         tick_cnt <= tick_cnt + TICK_W'(1);
         tick     <= 1'b0;
      end
   end

   // Seconds clear coincides with the return to RUN.
   always_ff @(posedge clk or posedge cr) begin
      if (cr) clr_sec <= 1'b0;
      else    clr_sec <= (state == MODE_SET_MIN) & p_mode;
   end

   assign mode = state;

`ifdef CLOCK_BLINK_EN
   localparam int unsigned BLINK_W = cnt_w(BLINK_DIV);

   logic [BLINK_W-1:0] blink_cnt;
   logic               phase;

   // Blink phase; cleared on mode change so the new field starts visible.
   always_ff @(posedge clk or posedge cr) begin
      if (cr) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (mode_chg) begin
         blink_cnt <= '0;
         phase     <= 1'b0;
      end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + BLINK_W'(1);
      end
   end

   assign blank = {(state == MODE_SET_HR) & phase, (state == MODE_SET_MIN) & phase};
`else
   assign blank = 2'b00;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl (TICK_DIV=10, DB_CYCLES=4, BLINK_DIV=8).
module tb_clock_ctrl;
   import clock_ctrl_pkg::*;

   localparam int TICK_DIV  = 10;
   localparam int DB_CYCLES = 4;
   localparam int PRESS_LAT = 2 + DB_CYCLES + 1;
`ifdef CLOCK_BLINK_EN
   localparam int BLINK_DIV = 8;
`endif

   logic       clk = 1'b0;
   logic       cr = 1'b1;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic       rco_sec = 1'b0;
   logic       rco_min = 1'b0;
   logic       en_sec, en_min, en_hr, clr_sec;
   logic [1:0] mode;
   logic [1:0] blank;

   always #5 clk = ~clk;

   clock_ctrl #(
      .TICK_DIV  (TICK_DIV),
      .DB_CYCLES (DB_CYCLES)
`ifdef CLOCK_BLINK_EN
      ,
      .BLINK_DIV (BLINK_DIV)
`endif
   ) dut (
      .clk      (clk),
      .cr       (cr),
      .btn_mode (btn_mode),
      .btn_inc  (btn_inc),
      .rco_sec  (rco_sec),
      .rco_min  (rco_min),
      .en_sec   (en_sec),
      .en_min   (en_min),
      .en_hr    (en_hr),
      .clr_sec  (clr_sec),
      .mode     (mode),
      .blank    (blank)
   );

   // Stimulus schedule: which 0=mode, 1=inc, 2=both; len = samples held high.
   typedef struct {int at; int which; int len;} press_t;
   // Scoreboard entries: press pulse expected at sample 'at'.
   typedef struct {int at; int which;} ev_t;

   press_t sched[$];
   ev_t    ev_q[$];
   int     mode_hold, inc_hold;
   int     m_mode, m_sync;
   logic   m_clr_pend;
   int     n_checks = 0;
   int     n_fail = 0;

   // Observed vector {mode, blank, clr_sec, en_hr, en_min, en_sec}.
   function automatic logic [7:0] obs_vec();
      return {mode, blank, clr_sec, en_hr, en_min, en_sec};
   endfunction

   task automatic do_reset();
      @(posedge clk);
      #1;
      cr = 1'b1;
      btn_mode = 1'b0;
      btn_inc = 1'b0;
      mode_hold = 0;
      inc_hold = 0;
      ev_q.delete();
      sched.delete();
      repeat (2) @(posedge clk);
      #1;
      cr = 1'b0;
      m_mode = 0;
      m_sync = 0;
      m_clr_pend = 1'b0;
   endtask

   // Drive buttons for sample j; a clean press queues its expected pulse.
   task automatic drive_step(input int j);
      for (int k = 0; k < sched.size(); k++) begin
         if (sched[k].at == j) begin
            if (sched[k].which != 1) mode_hold = sched[k].len;
            if (sched[k].which != 0) inc_hold = sched[k].len;
            if (sched[k].len >= DB_CYCLES + 2) begin
               if (sched[k].which != 1) ev_q.push_back('{j + PRESS_LAT, 0});
               if (sched[k].which != 0) ev_q.push_back('{j + PRESS_LAT, 1});
            end
         end
      end
      btn_mode = (mode_hold > 0);
      if (mode_hold > 0) mode_hold--;
      btn_inc = (inc_hold > 0);
      if (inc_hold > 0) inc_hold--;
   endtask

   // Reference model: expected outputs at sample j, then advance model state.
   task automatic model_step(input int j, output logic [7:0] e);
      logic pm, pi, tick;
      int   k;
      pm = 1'b0;
      pi = 1'b0;
      k = 0;
      while (k < ev_q.size()) begin
         if (ev_q[k].at == j) begin
            if (ev_q[k].which == 0) pm = 1'b1;
            else                    pi = 1'b1;
            ev_q.delete(k);
         end else begin
            k++;
         end
      end
      tick = (j > m_sync) && (((j - m_sync) % TICK_DIV) == 0);
      e = 8'h00;
      e[7:6] = 2'(m_mode);
      e[3] = m_clr_pend;
      case (m_mode)
         0: begin
            e[0] = tick;
            e[1] = tick & rco_sec;
            e[2] = tick & rco_sec & rco_min;
         end
         1: e[2] = pi & ~pm;
         2: e[1] = pi & ~pm;
         default: ;
      endcase
`ifdef CLOCK_BLINK_EN
      e[5] = (m_mode == 1) && ((((j - m_sync) / BLINK_DIV) % 2) == 1);
      e[4] = (m_mode == 2) && ((((j - m_sync) / BLINK_DIV) % 2) == 1);
`endif
      m_clr_pend = pm && (m_mode == 2);
      if (pm) begin
         m_mode = (m_mode == 2) ? 0 : m_mode + 1;
         m_sync = j + 1;
      end
   endtask

   task automatic test_reset();
      logic [7:0] o, e;
      #1;
      n_checks++;
      if (obs_vec() !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_initial: got %b expected %b", obs_vec(), 8'h00);
      end
      do_reset();
      sched.push_back('{2, 0, 8});
      sched.push_back('{20, 1, 8});
      for (int j = 0; j < 24; j++) begin
         @(negedge clk); drive_step(j); #1;
         model_step(j, e); o = obs_vec();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_pre j=%0d: got %b expected %b", j, o, e);
         end
      end
      // Async reset mid-debounce and mid-count, while in SET_HR.
      #2;
      cr = 1'b1;
      btn_inc = 1'b0;
      inc_hold = 0;
      #1;
      n_checks++;
      if (obs_vec() !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_async: got %b expected %b", obs_vec(), 8'h00);
      end
      do_reset();
      for (int j = 0; j < 25; j++) begin
         @(negedge clk); drive_step(j); #1;
         model_step(j, e); o = obs_vec();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_release j=%0d: got %b expected %b", j, o, e);
         end
      end
   endtask

   task automatic test_run();
      logic [7:0] o, e;
      rco_sec = 1'b0;
      rco_min = 1'b0;
      do_reset();
      for (int j = 0; j < 45; j++) begin
         @(negedge clk);
         if (j == 25) rco_sec = 1'b1;
         if (j == 35) rco_min = 1'b1;
         drive_step(j); #1;
         model_step(j, e); o = obs_vec();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL run j=%0d: got %b expected %b", j, o, e);
         end
      end
      rco_sec = 1'b0;
      rco_min = 1'b0;
   endtask

   task automatic test_debounce();
      logic [7:0] o, e;
      logic [1:0] prev;
      int         changes;
      do_reset();
      sched.push_back('{2, 0, 2});
      sched.push_back('{40, 0, 50});
      prev = 2'd0;
      changes = 0;
      for (int j = 0; j < 100; j++) begin
         @(negedge clk); drive_step(j); #1;
         model_step(j, e); o = obs_vec();
         if (o[7:6] !== prev) changes++;
         prev = o[7:6];
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL debounce j=%0d: got %b expected %b", j, o, e);
         end
      end
      n_checks++;
      if (changes !== 1) begin
         n_fail++;
         $display("FAIL debounce_changes: got %0d expected %0d", changes, 1);
      end
   endtask

   task automatic test_set_hr();
      logic [7:0] o, e;
      int         hr_cnt, other_cnt;
      do_reset();
      sched.push_back('{2, 0, 8});
      sched.push_back('{20, 1, 8});
      sched.push_back('{45, 1, 8});
      sched.push_back('{70, 1, 8});
      hr_cnt = 0;
      other_cnt = 0;
      for (int j = 0; j < 120; j++) begin
         @(negedge clk); drive_step(j); #1;
         model_step(j, e); o = obs_vec();
         if (j >= 10) begin
            hr_cnt += int'(o[2]);
            other_cnt += int'(o[0] | o[1]);
         end
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL set_hr j=%0d: got %b expected %b", j, o, e);
         end
      end
      n_checks++;
      if (hr_cnt !== 3) begin
         n_fail++;
         $display("FAIL set_hr_count: got %0d expected %0d", hr_cnt, 3);
      end
      n_checks++;
      if (other_cnt !== 0) begin
         n_fail++;
         $display("FAIL set_hr_frozen: got %0d expected %0d", other_cnt, 0);
      end
   endtask

   task automatic test_set_min_exit();
      logic [7:0] o, e;
      int         clr_cnt;
      do_reset();
      sched.push_back('{2, 0, 8});
      sched.push_back('{25, 0, 8});
      sched.push_back('{45, 1, 8});
      sched.push_back('{70, 0, 8});
      clr_cnt = 0;
      for (int j = 0; j < 100; j++) begin
         @(negedge clk); drive_step(j); #1;
         model_step(j, e); o = obs_vec();
         clr_cnt += int'(o[3]);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL set_min_exit j=%0d: got %b expected %b", j, o, e);
         end
      end
      n_checks++;
      if (clr_cnt !== 1) begin
         n_fail++;
         $display("FAIL clr_sec_count: got %0d expected %0d", clr_cnt, 1);
      end
   endtask

   task automatic test_coincident();
      logic [7:0] o, e;
      int         min_cnt;
      do_reset();
      sched.push_back('{2, 0, 8});
      sched.push_back('{25, 0, 8});
      sched.push_back('{50, 2, 8});
      sched.push_back('{70, 1, 8});
      min_cnt = 0;
      for (int j = 0; j < 90; j++) begin
         @(negedge clk); drive_step(j); #1;
         model_step(j, e); o = obs_vec();
         min_cnt += int'(o[1]);
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL coincident j=%0d: got %b expected %b", j, o, e);
         end
      end
      n_checks++;
      if (min_cnt !== 0) begin
         n_fail++;
         $display("FAIL coincident_en_min: got %0d expected %0d", min_cnt, 0);
      end
   endtask

   task automatic test_blink();
      logic [7:0] o, e;
      do_reset();
      sched.push_back('{2, 0, 8});
      sched.push_back('{40, 0, 8});
      for (int j = 0; j < 80; j++) begin
         @(negedge clk); drive_step(j); #1;
         model_step(j, e); o = obs_vec();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL blink j=%0d: got %b expected %b", j, o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_debounce();
      test_set_hr();
      test_set_min_exit();
      test_coincident();
      test_blink();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
